mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised synchronous up/down counter with programmable modulus, parallel load, synchronous clear, and an optional one-shot mode. It replaces ripple-clocked counter chains with a single-clock design. All state changes on one edge, so the outputs are glitch-free and usable as timing-closed enables elsewhere in the design. It provides a binary count, a registered Gray-coded copy, a terminal-count flag and a wrap pulse for cascading.

## Interface
- WIDTH, 4, counter width in bits; legal range is 1 to 32.
- MODULUS, 16, number of count states, so the count runs 0 to MODULUS-1; legal range is 2 to 2^WIDTH.
- ONESHOT, 0, selects the mode: 0 = continuous wrap, 1 = stop at terminal count.
- clk  input  1  single clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable for the current cycle.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value applied when load is high.
- q  output  WIDTH  registered binary count.
- q_gray  output  WIDTH  registered Gray code of q, equal to q ^ (q >> 1).
- tc  output  1  combinational terminal-count flag.
- wrap  output  1  registered one-cycle pulse after a wrap.
- done  output  1  sticky flag, one-shot mode only.

## Operation
- Reset (rst = 0, asynchronous):
  - q = 0, q_gray = 0, wrap = 0, done = 0 immediately.
  - Reset held across an edge keeps these values.
  - Release is synchronous to the design: the first count occurs on the first rising edge with rst = 1.
- Per-edge priority (highest first):
  1. clear: q = 0, done = 0.
  2. load: q = min(load_val, MODULUS-1), done = 0.
  3. en && !done: count.
  4. Otherwise: hold.
- Counting up:
  - q < MODULUS-1: q = q + 1.
  - q == MODULUS-1, ONESHOT = 0: q = 0 and wrap pulses.
  - q == MODULUS-1, ONESHOT = 1: q holds, done = 1, no wrap pulse.
- Counting down:
  - q > 0: q = q - 1.
  - q == 0, ONESHOT = 0: q = MODULUS-1 and wrap pulses.
  - q == 0, ONESHOT = 1: q holds, done = 1, no wrap pulse.
- tc = (up_dn && q == MODULUS-1) || (!up_dn && q == 0). It follows up_dn combinationally, independent of en.
- Once done = 1, en is ignored. Only clear, load or reset releases done. With ONESHOT = 0, done stays 0 permanently.
- load_val >= MODULUS is clamped to MODULUS-1. An out-of-range value is never stored.
- Next-state arithmetic is WIDTH bits wide. When MODULUS = 2^WIDTH, wrap uses the explicit compare, not natural overflow, so both cases share one path.
- Simultaneous events:
  - clear and load together: clear wins.
  - load and en together: load wins, with no count and no wrap.
  - Changing up_dn changes the direction on that same edge; there is no settling cycle.

## Timing
- q, q_gray, wrap and done are registered and change only on the rising clk edge or on rst assertion.
- q_gray is computed from next-q, so it matches gray(q) in the same cycle with zero extra latency.
- Count latency: an input sampled at edge N is visible on q after edge N.
- wrap is high for exactly the cycle following the wrapping edge. Back-to-back wraps (MODULUS = 2, en held high) give wrap high on consecutive cycles.
- tc is combinational from q and up_dn. Cascading stages use en_next = en && tc on the same edge.
- Reset asserted mid-count forces all outputs to their reset values asynchronously. No partial update survives.

## Test plan
- Reset and up-wrap (WIDTH=4, MODULUS=10, ONESHOT=0): hold rst low, then release with en=1, up_dn=1.
  - q reads 0,1,…,9,0.
  - tc is high while q=9.
  - wrap is high only in the cycle where q=0 after 9.
  - q_gray = 0xD when q = 9.
- Down-wrap and direction change: load 2, then en=1 with up_dn=0.
  - q reads 2,1,0,9 with wrap pulsing once.
  - Set up_dn=1 at q=9: next q=0 with wrap pulsing, and tc switches immediately.
- Load clamp and priority:
  - load_val=15 with MODULUS=10: q becomes 9.
  - clear=1 and load=1 on the same edge: q becomes 0.
  - load=1 and en=1 together: q equals the loaded value with no count.
- One-shot (ONESHOT=1, MODULUS=5): count up from 0.
  - q saturates at 4 and done goes to 1 on the next enabled edge, with no wrap.
  - Further en pulses leave q at 4.
  - A clear gives q=0 and done=0.
- Asynchronous reset mid-count: assert rst low between edges at q=6.
  - q, q_gray, wrap and done go to 0 before the next edge.
  - After release, counting resumes from 0.
- Full-range modulus (WIDTH=3, MODULUS=8) with en toggling every other cycle:
  - q advances only on enabled edges.
  - q wraps 7 to 0 and wrap pulses exactly once per wrap.

Source files
------------

// File: rtl/mod_updown_counter_if.sv
// mod_updown_counter_if: control inputs (en/up_dn/clear/load/load_val) and count outputs (q/q_gray/tc/wrap/done) of the counter
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic en;
  logic up_dn;
  logic clear;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_gray;
  logic tc;
  logic wrap;
  logic done;
  modport master (
    output en, up_dn, clear, load, load_val,
    input q, q_gray, tc, wrap, done
  );
  modport slave (
    input en, up_dn, clear, load, load_val,
    output q, q_gray, tc, wrap, done
  );
endinterface

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulus up/down counter with clamped load, clear and one-shot; ports clk, rst (async active-low), bus (slave: en/up_dn/clear/load/load_val in, q/q_gray/tc/wrap/done out)
module mod_updown_counter #(
  parameter int WIDTH = 4,
  parameter longint MODULUS = 16,
  parameter bit ONESHOT = 1'b0
) (
  input logic clk,
  input logic rst,
  mod_updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] top_val = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q, q_gray, q_nxt, step_val, ld_val;
  logic wrap, done, at_end, cnt, hit;
  always_comb begin
    at_end = bus.up_dn ? (q == top_val) : (q == '0);
    cnt = bus.en && !done;
    hit = cnt && at_end;
    step_val = bus.up_dn ? (at_end ? '0 : q + WIDTH'(1)) : (at_end ? top_val : q - WIDTH'(1));
    ld_val = (bus.load_val > top_val) ? top_val : bus.load_val;
    q_nxt = bus.clear ? '0 : bus.load ? ld_val : (cnt && !(hit && ONESHOT)) ? step_val : q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= '0;
      q_gray <= '0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      q <= q_nxt;
      q_gray <= q_nxt ^ (q_nxt >> 1);
      wrap <= !bus.clear && !bus.load && hit && !ONESHOT;
      done <= (bus.clear || bus.load) ? 1'b0 : (done || (hit && ONESHOT));
    end
  assign bus.q = q;
  assign bus.q_gray = q_gray;
  assign bus.tc = at_end;
  assign bus.wrap = wrap;
  assign bus.done = done;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: scoreboard bench over three counter configurations (mod 10, one-shot mod 5, full-range mod 8)
module tb_mod_updown_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mod_updown_counter_if #(.WIDTH(4)) ia ();
  mod_updown_counter_if #(.WIDTH(4)) ib ();
  mod_updown_counter_if #(.WIDTH(3)) ic ();
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  mod_updown_counter #(.WIDTH(4), .MODULUS(5), .ONESHOT(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  mod_updown_counter #(.WIDTH(3), .MODULUS(8), .ONESHOT(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(ic));
  typedef struct {int q; bit wrap; bit done;} st_t;
  typedef struct {string tag; int d; int q; bit wrap; bit done; bit up;} exp_t;
  st_t ms[3];
  int mods[3] = '{10, 5, 8};
  bit oss[3] = '{1'b0, 1'b1, 1'b0};
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic st_t model(st_t s, int m, bit os, bit en, bit up, bit clr, bit ld, int lv);
    st_t n = s;
    n.wrap = 1'b0;
    if (clr) begin
      n.q = 0;
      n.done = 1'b0;
    end else if (ld) begin
      n.q = (lv > m - 1) ? m - 1 : lv;
      n.done = 1'b0;
    end else if (en && !s.done) begin
      if (up) begin
        if (s.q < m - 1) n.q = s.q + 1;
        else if (os) n.done = 1'b1;
        else begin n.q = 0; n.wrap = 1'b1; end
      end else begin
        if (s.q > 0) n.q = s.q - 1;
        else if (os) n.done = 1'b1;
        else begin n.q = m - 1; n.wrap = 1'b1; end
      end
    end
    return n;
  endfunction
  task automatic set_in(int d, bit en, bit up, bit clr, bit ld, int lv);
    logic [31:0] v = lv;
    case (d)
      0: begin ia.en = en; ia.up_dn = up; ia.clear = clr; ia.load = ld; ia.load_val = v[3:0]; end
      1: begin ib.en = en; ib.up_dn = up; ib.clear = clr; ib.load = ld; ib.load_val = v[3:0]; end
      default: begin ic.en = en; ic.up_dn = up; ic.clear = clr; ic.load = ld; ic.load_val = v[2:0]; end
    endcase
  endtask
  task automatic observe(int d, output logic [31:0] q, output logic [31:0] g, output logic tc, output logic w, output logic dn);
    case (d)
      0: begin q = 32'(ia.q); g = 32'(ia.q_gray); tc = ia.tc; w = ia.wrap; dn = ia.done; end
      1: begin q = 32'(ib.q); g = 32'(ib.q_gray); tc = ib.tc; w = ib.wrap; dn = ib.done; end
      default: begin q = 32'(ic.q); g = 32'(ic.q_gray); tc = ic.tc; w = ic.wrap; dn = ic.done; end
    endcase
  endtask
  task automatic check_zero(int d, string tag);
    logic [31:0] q, g;
    logic tc, w, dn;
    observe(d, q, g, tc, w, dn);
    check({tag, "_q"}, q, 0);
    check({tag, "_gray"}, g, 0);
    check({tag, "_wrap"}, 32'(w), 0);
    check({tag, "_done"}, 32'(dn), 0);
  endtask
  task automatic step(int d, bit en, bit up, bit clr, bit ld, int lv, string tag);
    exp_t e;
    logic [31:0] q, g;
    logic tc, w, dn;
    set_in(d, en, up, clr, ld, lv);
    ms[d] = model(ms[d], mods[d], oss[d], en, up, clr, ld, lv);
    sb.push_back('{tag, d, ms[d].q, ms[d].wrap, ms[d].done, up});
    @(posedge clk);
    #1;
    set_in(d, 1'b0, up, 1'b0, 1'b0, 0);
    e = sb.pop_front();
    observe(e.d, q, g, tc, w, dn);
    check({e.tag, "_q"}, q, 32'(e.q));
    check({e.tag, "_gray"}, g, 32'(e.q ^ (e.q >> 1)));
    check({e.tag, "_wrap"}, 32'(w), 32'(e.wrap));
    check({e.tag, "_done"}, 32'(dn), 32'(e.done));
    check({e.tag, "_tc"}, 32'(tc), 32'(e.up ? (e.q == mods[e.d] - 1) : (e.q == 0)));
  endtask
  task automatic reset_models();
    for (int i = 0; i < 3; i++) ms[i] = '{0, 1'b0, 1'b0};
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [31:0] q, g;
    logic tc, w, dn;
    reset_models();
    for (int d = 0; d < 3; d++) set_in(d, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    set_in(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_zero(d, "rst_hold");
    rst = 1'b1;
    for (int i = 0; i < 11; i++) step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "up_a");
    step(0, 1'b0, 1'b1, 1'b0, 1'b1, 2, "ld2");
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "down_a");
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    #1;
    observe(0, q, g, tc, w, dn);
    check("tc_dn_at9", 32'(tc), 0);
    set_in(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    #1;
    observe(0, q, g, tc, w, dn);
    check("tc_up_at9", 32'(tc), 1);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "dir_wrap");
    step(0, 1'b0, 1'b1, 1'b0, 1'b1, 15, "clamp");
    step(0, 1'b0, 1'b1, 1'b1, 1'b1, 5, "clr_ld");
    step(0, 1'b1, 1'b1, 1'b0, 1'b1, 5, "ld_en");
    for (int i = 0; i < 7; i++) step(1, 1'b1, 1'b1, 1'b0, 1'b0, 0, "os_up");
    step(1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "os_clr");
    step(1, 1'b1, 1'b1, 1'b0, 1'b0, 0, "os_again");
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "to6");
    #3;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_zero(d, "rst_async");
    reset_models();
    #1;
    rst = 1'b1;
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "resume");
    for (int i = 0; i < 20; i++) step(2, (i % 2) == 0, 1'b1, 1'b0, 1'b0, 0, "full_c");
    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
